// File: rtl/sha_feeder_pkg.sv
// Shared types and sizes for the SHA-256 message feeder and its digest serializer.
package sha_feeder_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FILL     = 3'd1,
      SEND     = 3'd2,
      WAIT_DIG = 3'd3,
      OUT      = 3'd4
   } state_t;

   localparam int DATA_W    = 32;
   localparam int BLK_WORDS = 16;
   localparam int DIG_WORDS = 8;
   localparam int BLK_W     = 512;
   localparam int DIG_W     = 256;
   localparam int LEN_W     = 64;

endpackage

// File: rtl/sha_dig_ser.sv
// Captures the 256-bit digest from the hash core and streams it out as eight
// 32-bit words, H0 first, with a valid/ready handshake.
module sha_dig_ser
   import sha_feeder_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cap_en,
   input  logic              dig_valid,
   input  logic [DIG_W-1:0]  dig_data,
   input  logic              m_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              done
);

   logic [DIG_W-1:0] dig_p0;
   logic [2:0]       idx_p0;
   logic             vld_p0;
   logic             word_fire;
   logic             idx_last;

   assign word_fire = vld_p0 & m_ready;
   assign idx_last  = (idx_p0 == 3'(DIG_WORDS - 1));

   // p0: digest register and word index; capture only when the top is waiting for it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dig_p0 <= '0;
         idx_p0 <= '0;
         vld_p0 <= 1'b0;
      end else if (cap_en && dig_valid) begin
         dig_p0 <= dig_data;
         idx_p0 <= '0;
         vld_p0 <= 1'b1;
      end else if (word_fire) begin
         idx_p0 <= idx_p0 + 3'd1;
         if (idx_last) begin
            vld_p0 <= 1'b0;
         end
      end
   end

   assign m_valid = vld_p0;
   assign m_data  = dig_p0[DIG_W-1 - DATA_W*int'(idx_p0) -: DATA_W];
   assign m_last  = vld_p0 & idx_last;
   assign done    = word_fire & idx_last;

endmodule

// File: rtl/sha_msg_feeder.sv
// Packs 32-bit host words into 512-bit blocks for a SHA-256 core and returns the digest
// as eight words. Define SHA_FEEDER_BSWAP_EN to take host bytes little-endian (first byte in [7:0]).
module sha_msg_feeder
   import sha_feeder_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic [1:0]        s_last_bytes,
   output logic              blk_valid,
   input  logic              blk_ready,
   output logic [BLK_W-1:0]  blk_data,
   output logic              blk_last,
   output logic [LEN_W-1:0]  blk_msg_len,
   input  logic              dig_valid,
   input  logic [DIG_W-1:0]  dig_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              busy
);

   state_t                 state;
   logic [3:0]             wcnt;
   logic [LEN_W-4:0]       byte_cnt;
   logic [BLK_W-1:0]       blk_p0;
   logic                   blk_last_p0;

   logic                   s_fire;
   logic                   ser_done;
   logic [DATA_W-1:0]      word_in;
   logic [DATA_W-1:0]      word_msk;
   logic [2:0]             word_bytes;
   logic [LEN_W-4:0]       byte_base;

   // Keep the leading nb bytes of a word; nb = 0 means the whole word is valid.
   function automatic logic [DATA_W-1:0] keep_bytes(input logic [DATA_W-1:0] w,
                                                    input logic [1:0]        nb);
      case (nb)
         2'd1:    keep_bytes = {w[31:24], 24'h000000};
         2'd2:    keep_bytes = {w[31:16], 16'h0000};
         2'd3:    keep_bytes = {w[31:8],  8'h00};
         default: keep_bytes = w;
      endcase
   endfunction

`ifdef SHA_FEEDER_BSWAP_EN
   function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
      byte_swap = {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   assign word_in = byte_swap(s_data);
`else
   assign word_in = s_data;
`endif

   assign word_msk   = s_last ? keep_bytes(word_in, s_last_bytes) : word_in;
   assign word_bytes = (s_last && (s_last_bytes != 2'd0)) ? {1'b0, s_last_bytes} : 3'd4;
   assign byte_base  = (state == IDLE) ? '0 : byte_cnt;

   assign s_ready     = (state == IDLE) || (state == FILL);
   assign s_fire      = s_valid & s_ready;
   assign blk_valid   = (state == SEND);
   assign busy        = (state != IDLE);
   assign blk_data    = blk_p0;
   assign blk_last    = blk_last_p0;
   assign blk_msg_len = blk_last_p0 ? {byte_cnt, 3'b000} : '0;

   // p0: block assembly register, counters and message FSM
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         wcnt        <= '0;
         byte_cnt    <= '0;
         blk_p0      <= '0;
         blk_last_p0 <= 1'b0;
      end else begin
         case (state)
            IDLE, FILL: begin
               if (s_fire) begin
                  blk_p0[BLK_W-1 - DATA_W*int'(wcnt) -: DATA_W] <= word_msk;
                  wcnt     <= wcnt + 4'd1;
                  byte_cnt <= byte_base + (LEN_W-3)'(word_bytes);
                  if (s_last || (wcnt == 4'(BLK_WORDS - 1))) begin
                     state       <= SEND;
                     blk_last_p0 <= s_last;
                  end else begin
                     state <= FILL;
                  end
               end else if (state == IDLE) begin
                  byte_cnt <= '0;
               end
            end
            SEND: begin
               // Clearing here leaves zeros in the unfilled words of a short next block.
               if (blk_ready) begin
                  blk_p0      <= '0;
                  wcnt        <= '0;
                  blk_last_p0 <= 1'b0;
                  state       <= blk_last_p0 ? WAIT_DIG : FILL;
               end
            end
            WAIT_DIG: begin
               if (dig_valid) begin
                  state <= OUT;
               end
            end
            OUT: begin
               if (ser_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sha_dig_ser u_dig_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap_en    (state == WAIT_DIG),
      .dig_valid (dig_valid),
      .dig_data  (dig_data),
      .m_ready   (m_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_last    (m_last),
      .done      (ser_done)
   );

endmodule

// File: doc/sha_msg_feeder.md
SHA_MSG_FEEDER -- requirements
Module: sha_msg_feeder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk, rst_n.
REQ-002 The ports SHALL be (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  host word valid
- s_ready  out  1  feeder accepts host word
- s_data  in  32  host message word, first byte in [31:24]
- s_last  in  1  final word of message
- s_last_bytes  in  2  valid bytes in last word (0 means 4)
- blk_valid  out  1  512-bit block presented to hash core
- blk_ready  in  1  hash core accepts block
- blk_data  out  512  block, word 0 in [511:480]
- blk_last  out  1  block is final block of message
- blk_msg_len  out  64  total message length in bits, valid when blk_last=1
- dig_valid  in  1  hash core digest valid (single-cycle pulse)
- dig_data  in  256  digest, H0 in [255:224]
- m_valid  out  1  digest word valid
- m_ready  in  1  sink accepts digest word
- m_data  out  32  digest word, H0 first
- m_last  out  1  eighth digest word
- busy  out  1  state != IDLE

Function
REQ-003 The FSM SHALL have states IDLE, FILL, SEND, WAIT_DIG, OUT; IDLE->FILL on the first accepted word, with no idle gap required.
REQ-004 s_ready SHALL be 1 only in IDLE and FILL; a word transfers on s_valid&s_ready, and s_valid with s_ready=0 SHALL be ignored.
REQ-005 Accepted word n (0..15) SHALL be written to blk_data[511-32n -: 32]; the 4-bit word counter SHALL reset to 0 on each block handshake.
REQ-006 On the 16th accepted word, or on any accepted word with s_last=1, the FSM SHALL enter SEND and blk_valid SHALL assert the next cycle.
REQ-007 On a partial last word, bytes beyond s_last_bytes SHALL be zero; unfilled words of a short last block SHALL be zero.
REQ-008 The byte counter SHALL be 61 bits, wrap modulo 2^61, and clear in IDLE; blk_msg_len SHALL equal {byte_count,3'b000}, and SHALL be 0 when blk_last=0.
REQ-009 blk_data, blk_last and blk_msg_len SHALL stay stable while blk_valid=1 and blk_ready=0.
REQ-010 On blk_valid&blk_ready, the FSM SHALL go to FILL if blk_last=0, else to WAIT_DIG.
REQ-011 In WAIT_DIG, dig_valid SHALL capture dig_data and move the FSM to OUT; dig_valid in any other state SHALL be ignored.
REQ-012 OUT SHALL emit 8 words, H0 first, with m_valid held until m_ready; m_last SHALL be 1 on word 7, and the handshake of word 7 SHALL return the FSM to IDLE.
REQ-013 A message that ends exactly on a 16-word boundary SHALL produce one full block with blk_last=1; no empty block is generated, since padding is the core's task.

Reset
REQ-014 With rst_n=0 at a clock edge, the following SHALL hold next cycle, regardless of state:
- FSM=IDLE; counters=0
- blk_data=0; digest register=0
- s_ready=1
- all other outputs 0
REQ-015 A block or digest in flight at reset SHALL be discarded without any further output.

Configuration
REQ-016 With SHA_FEEDER_BSWAP_EN defined, s_data SHALL be byte-reversed on input, so the first byte is taken from [7:0], and s_last_bytes SHALL count from [7:0] upward; without the macro, the byte order SHALL be as in REQ-002.

Structure
REQ-017 Package sha_feeder_pkg SHALL hold:
- the state enum
- BLK_WORDS=16, DIG_WORDS=8, BLK_W=512, DIG_W=256, LEN_W=64
REQ-018 Digest capture and serialization (REQ-011/012) SHALL be a sub-module sha_dig_ser.

Verification
REQ-019 The bench SHALL cover these scenarios:
- "abc": s_data=0x61626300, s_last=1, s_last_bytes=3 -> one block, blk_data[511:480]=0x61626300, rest 0, blk_last=1, blk_msg_len=24.
- 17 full words, last with s_last_bytes=0 -> block 1 has blk_last=0 and blk_msg_len=0; block 2 has word0=17th word, blk_msg_len=544.
- blk_ready=0 for 5 cycles during SEND -> blk_* stable and s_ready=0 throughout.
- dig_data=0xba7816bf...f20015ad with m_ready alternating 1/0 -> m_data sequence 0xba7816bf ... 0xf20015ad, m_last only on 0xf20015ad, then busy=0.
- rst_n=0 for 1 cycle after 7 words in FILL, then the "abc" message -> a clean single block, blk_msg_len=24.
- SHA_FEEDER_BSWAP_EN defined, s_data=0x00636261, s_last_bytes=3 -> blk_data[511:480]=0x61626300.
